// File: rtl/ctrl_pkg.sv
// Shared opcodes, control-word layout and fetch length for the control sequencer.
// Consumed by microcode_rom and control_sequencer.
package ctrl_pkg;

    localparam int FETCH_STEPS = 2;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam int CW_PC_OUT   = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_IN   = 3;
    localparam int CW_RAM_IN   = 4;
    localparam int CW_RAM_OUT  = 5;
    localparam int CW_IR_IN    = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_A_IN     = 8;
    localparam int CW_A_OUT    = 9;
    localparam int CW_B_IN     = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_FLAGS_IN = 13;
    localparam int CW_OUT_IN   = 14;
    localparam int CW_W        = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-datapath bundle: run/opcode/flags in, step, halt and
// every register's bus control out.
interface control_sequencer_if #(
    parameter int STEP_W   = 3,
    parameter int OPCODE_W = 4
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                carry_flag;
    logic                zero_flag;
    logic [STEP_W-1:0]   t_state;
    logic                halted;
    logic                pc_out;
    logic                pc_inc;
    logic                pc_load;
    logic                mar_in;
    logic                ram_in;
    logic                ram_out;
    logic                ir_in;
    logic                ir_out;
    logic                a_in;
    logic                a_out;
    logic                b_in;
    logic                alu_out;
    logic                alu_sub;
    logic                flags_in;
    logic                out_in;

    modport master (
        input  run, opcode, carry_flag, zero_flag,
        output t_state, halted,
        output pc_out, pc_inc, pc_load,
        output mar_in, ram_in, ram_out, ir_in, ir_out,
        output a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in
    );

    modport slave (
        output run, opcode, carry_flag, zero_flag,
        input  t_state, halted,
        input  pc_out, pc_inc, pc_load,
        input  mar_in, ram_in, ram_out, ir_in, ir_out,
        input  a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in
    );
endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, carry, zero) -> control word.
// Steps 0-1 are the shared fetch; later steps decode the opcode.
module microcode_rom
    import ctrl_pkg::*;
#(
    parameter int STEP_W   = 3,
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output ctrl_word_t          cw
);

    logic t0, t1, t2, t3, t4;

    assign t0 = (step == STEP_W'(0));
    assign t1 = (step == STEP_W'(1));
    assign t2 = (step == STEP_W'(FETCH_STEPS));
    assign t3 = (step == STEP_W'(FETCH_STEPS + 1));
    assign t4 = (step == STEP_W'(FETCH_STEPS + 2));

    always_comb begin
        cw = '0;
        unique case (1'b1)
            t0: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
            t1: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN)
                   | cw_bit(CW_PC_INC);
            default: begin
                case (opcode)
                    OP_LDA: begin
                        if (t2)
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                        else if (t3)
                            cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
                    end
                    OP_ADD, OP_SUB: begin
                        if (t2)
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                        else if (t3)
                            cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
                        else if (t4) begin
                            cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN)
                               | cw_bit(CW_FLAGS_IN);
                            cw[CW_ALU_SUB] = (opcode == OP_SUB);
                        end
                    end
                    OP_STA: begin
                        if (t2)
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                        else if (t3)
                            cw = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
                    end
                    OP_LDI: begin
                        if (t2)
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_A_IN);
                    end
                    OP_JMP: begin
                        if (t2)
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                    end
                    OP_JC: begin
                        if (t2) begin
                            cw[CW_IR_OUT]  = 1'b1;
                            cw[CW_PC_LOAD] = carry_flag;
                        end
                    end
                    OP_JZ: begin
                        if (t2) begin
                            cw[CW_IR_OUT]  = 1'b1;
                            cw[CW_PC_LOAD] = zero_flag;
                        end
                    end
                    OP_OUT: begin
                        if (t2)
                            cw = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
                    end
                    OP_HLT: cw = '0;
                    default: cw = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Step counter, halt flag and run gating around microcode_rom.
// CTRL_SEQ_EARLY_END_EN: skip trailing empty execute steps.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 5,
    parameter int STEP_W    = 3,
    parameter int OPCODE_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    control_sequencer_if.master bus
);

    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_next;
    logic [STEP_W-1:0] step_inc;
    logic              halted;
    logic              halted_next;
    logic              active;
    logic              last;
    ctrl_word_t        cw_now;
    ctrl_word_t        ctrl;

    assign active   = bus.run && !halted;
    assign last     = (step == STEP_W'(NUM_STEPS - 1));
    assign step_inc = step + STEP_W'(1);

    microcode_rom #(
        .STEP_W   (STEP_W),
        .OPCODE_W (OPCODE_W)
    ) u_rom (
        .opcode     (bus.opcode),
        .step       (step),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .cw         (cw_now)
    );

`ifdef CTRL_SEQ_EARLY_END_EN
    ctrl_word_t cw_ahead;

    // Look one step ahead: an empty next step means the instruction is done.
    microcode_rom #(
        .STEP_W   (STEP_W),
        .OPCODE_W (OPCODE_W)
    ) u_rom_ahead (
        .opcode     (bus.opcode),
        .step       (step_inc),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .cw         (cw_ahead)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step   <= '0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (active) begin
            if (step == STEP_W'(FETCH_STEPS)
                && bus.opcode == OPCODE_W'(OP_HLT))
                halted_next = 1'b1;
            else if (last)
                step_next = '0;
`ifdef CTRL_SEQ_EARLY_END_EN
            else if (step >= STEP_W'(FETCH_STEPS) && cw_ahead == '0)
                step_next = '0;
`endif
            else
                step_next = step_inc;
        end
    end

    always_comb begin
        ctrl = '0;
        if (active)
            ctrl = cw_now;
    end

    assign bus.t_state  = step;
    assign bus.halted   = halted;
    assign bus.pc_out   = ctrl[CW_PC_OUT];
    assign bus.pc_inc   = ctrl[CW_PC_INC];
    assign bus.pc_load  = ctrl[CW_PC_LOAD];
    assign bus.mar_in   = ctrl[CW_MAR_IN];
    assign bus.ram_in   = ctrl[CW_RAM_IN];
    assign bus.ram_out  = ctrl[CW_RAM_OUT];
    assign bus.ir_in    = ctrl[CW_IR_IN];
    assign bus.ir_out   = ctrl[CW_IR_OUT];
    assign bus.a_in     = ctrl[CW_A_IN];
    assign bus.a_out    = ctrl[CW_A_OUT];
    assign bus.b_in     = ctrl[CW_B_IN];
    assign bus.alu_out  = ctrl[CW_ALU_OUT];
    assign bus.alu_sub  = ctrl[CW_ALU_SUB];
    assign bus.flags_in = ctrl[CW_FLAGS_IN];
    assign bus.out_in   = ctrl[CW_OUT_IN];

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against an instruction-level model.
// Honours CTRL_SEQ_EARLY_END_EN for expected instruction lengths.
module tb_control_sequencer;

    localparam int NUM_STEPS = 5;

    localparam logic [14:0] PC_OUT   = 15'h4000;
    localparam logic [14:0] PC_INC   = 15'h2000;
    localparam logic [14:0] PC_LOAD  = 15'h1000;
    localparam logic [14:0] MAR_IN   = 15'h0800;
    localparam logic [14:0] RAM_IN   = 15'h0400;
    localparam logic [14:0] RAM_OUT  = 15'h0200;
    localparam logic [14:0] IR_IN    = 15'h0100;
    localparam logic [14:0] IR_OUT   = 15'h0080;
    localparam logic [14:0] A_IN     = 15'h0040;
    localparam logic [14:0] A_OUT    = 15'h0020;
    localparam logic [14:0] B_IN     = 15'h0010;
    localparam logic [14:0] ALU_OUT  = 15'h0008;
    localparam logic [14:0] ALU_SUB  = 15'h0004;
    localparam logic [14:0] FLAGS_IN = 15'h0002;
    localparam logic [14:0] OUT_IN   = 15'h0001;
    localparam logic [14:0] BUS_OUTS =
        PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;

`ifdef CTRL_SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if #(.STEP_W(3), .OPCODE_W(4)) bus();

    control_sequencer #(
        .NUM_STEPS (NUM_STEPS),
        .STEP_W    (3),
        .OPCODE_W  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [14:0] got_cw;
    assign got_cw = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_in,
                     bus.ram_in, bus.ram_out, bus.ir_in, bus.ir_out,
                     bus.a_in, bus.a_out, bus.b_in, bus.alu_out,
                     bus.alu_sub, bus.flags_in, bus.out_in};

    int n_cmp = 0;
    int n_err = 0;
    int m_pos = 0;
    bit m_halted = 1'b0;
    int dut_t = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Execute-phase table, straight from the instruction list.
    function automatic logic [14:0] exec_word(input int op, input int k,
                                              input bit c, input bit z);
        logic [14:0] t [3];
        t = '{15'd0, 15'd0, 15'd0};
        case (op)
            0:  t = '{IR_OUT | MAR_IN, RAM_OUT | A_IN, 15'd0};
            1:  t = '{IR_OUT | MAR_IN, RAM_OUT | B_IN,
                      ALU_OUT | A_IN | FLAGS_IN};
            2:  t = '{IR_OUT | MAR_IN, RAM_OUT | B_IN,
                      ALU_OUT | A_IN | FLAGS_IN | ALU_SUB};
            4:  t = '{IR_OUT | MAR_IN, A_OUT | RAM_IN, 15'd0};
            5:  t = '{IR_OUT | A_IN, 15'd0, 15'd0};
            6:  t = '{IR_OUT | PC_LOAD, 15'd0, 15'd0};
            7:  t = '{IR_OUT | (c ? PC_LOAD : 15'd0), 15'd0, 15'd0};
            8:  t = '{IR_OUT | (z ? PC_LOAD : 15'd0), 15'd0, 15'd0};
            14: t = '{A_OUT | OUT_IN, 15'd0, 15'd0};
            default: t = '{15'd0, 15'd0, 15'd0};
        endcase
        if (k < 0 || k > 2) return 15'd0;
        return t[k];
    endfunction

    function automatic int instr_len(input int op, input bit c, input bit z);
        int n;
        n = 0;
        if (!EARLY) return NUM_STEPS;
        for (int k = 0; k < 3; k++)
            if (exec_word(op, k, c, z) != 15'd0) n = k + 1;
        return (2 + n < 3) ? 3 : 2 + n;
    endfunction

    function automatic logic [14:0] model_cw(input bit r, input int op,
                                             input bit c, input bit z);
        if (!r || m_halted) return 15'd0;
        if (m_pos == 0) return PC_OUT | MAR_IN;
        if (m_pos == 1) return RAM_OUT | IR_IN | PC_INC;
        return exec_word(op, m_pos - 2, c, z);
    endfunction

    task automatic step_cyc(input bit r, input int op, input bit c, input bit z);
        @(negedge clk);
        bus.run = r;
        bus.opcode = 4'(op);
        bus.carry_flag = c;
        bus.zero_flag = z;
        #1;
        chk($sformatf("t_state op%0d", op), 32'(bus.t_state), 32'(m_pos));
        chk($sformatf("halted op%0d", op), 32'(bus.halted), 32'(m_halted));
        chk($sformatf("ctrl op%0d t%0d", op, m_pos), 32'(got_cw),
            32'(model_cw(r, op, c, z)));
        chk("one_bus_driver", 32'($countones(got_cw & BUS_OUTS) <= 1), 32'd1);
        chk("inc_and_load", 32'(bus.pc_inc & bus.pc_load), 32'd0);
        @(posedge clk);
        #1;
        dut_t = int'(bus.t_state);
        if (r && !m_halted) begin
            if (op == 15 && m_pos == 2) m_halted = 1'b1;
            else if (m_pos + 1 >= instr_len(op, c, z)) m_pos = 0;
            else m_pos++;
        end
    endtask

    task automatic run_instr(input int op, input bit c, input bit z,
                             output int n);
        n = 0;
        do begin
            step_cyc(1'b1, op, c, z);
            n++;
        end while (dut_t != 0 && n < 20);
        if (n >= 20) chk("instr_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit started;
        int op, r, c, z, guard;

        bus.run = 1'b0;
        bus.opcode = 4'd0;
        bus.carry_flag = 1'b0;
        bus.zero_flag = 1'b0;

        repeat (2) @(negedge clk);
        bus.run = 1'b1;
        #1;
        chk("rst_t_state", 32'(bus.t_state), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_ctrl", 32'(got_cw), 32'(PC_OUT | MAR_IN));
        bus.run = 1'b0;
        reset_n = 1'b1;
        m_pos = 0;
        m_halted = 1'b0;

        run_instr(5, 1'b0, 1'b0, n);
        chk("len_ldi", 32'(n), EARLY ? 32'd3 : 32'd5);
        run_instr(7, 1'b0, 1'b0, n);
        run_instr(7, 1'b1, 1'b0, n);
        run_instr(8, 1'b0, 1'b1, n);

        // ADD paused at T3 for four cycles
        repeat (3) step_cyc(1'b1, 1, 1'b0, 1'b0);
        chk("add_at_t3", 32'(m_pos), 32'd3);
        repeat (4) step_cyc(1'b0, 1, 1'b0, 1'b0);
        run_instr(1, 1'b0, 1'b0, n);

        run_instr(0, 1'b0, 1'b0, n);
        chk("len_lda", 32'(n), EARLY ? 32'd4 : 32'd5);
        run_instr(1, 1'b1, 1'b1, n);
        chk("len_add", 32'(n), 32'd5);
        run_instr(3, 1'b0, 1'b0, n);
        chk("len_nop", 32'(n), EARLY ? 32'd3 : 32'd5);
        run_instr(4, 1'b0, 1'b0, n);
        chk("len_sta", 32'(n), EARLY ? 32'd4 : 32'd5);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 14);
            c = $urandom_range(0, 1);
            z = $urandom_range(0, 1);
            started = 1'b0;
            guard = 0;
            while (!(started && m_pos == 0) && guard < 100) begin
                r = ($urandom_range(0, 3) != 0);
                step_cyc(r[0], op, c[0], z[0]);
                if (r != 0) started = 1'b1;
                guard++;
            end
            if (guard >= 100) chk("rand_timeout", 32'(guard), 32'd0);
        end

        // STA interrupted by async reset between edges of T3
        repeat (3) step_cyc(1'b1, 4, 1'b0, 1'b0);
        @(negedge clk);
        bus.run = 1'b1;
        bus.opcode = 4'd4;
        #1;
        chk("sta_t3_ram_in", 32'(bus.ram_in), 32'd1);
        chk("sta_t3_step", 32'(bus.t_state), 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_t_state", 32'(bus.t_state), 32'd0);
        chk("async_rst_ram_in", 32'(bus.ram_in), 32'd0);
        chk("async_rst_ctrl", 32'(got_cw), 32'(PC_OUT | MAR_IN));
        bus.run = 1'b0;
        reset_n = 1'b1;
        m_pos = 0;
        m_halted = 1'b0;

        repeat (3) step_cyc(1'b1, 15, 1'b0, 1'b0);
        chk("hlt_flag", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 20; i++)
            step_cyc(1'b1, 15, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        @(negedge clk);
        bus.run = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("hlt_rst_t_state", 32'(bus.t_state), 32'd0);
        chk("hlt_rst_halted", 32'(bus.halted), 32'd0);
        reset_n = 1'b1;
        m_pos = 0;
        m_halted = 1'b0;

        run_instr(14, 1'b0, 1'b0, n);
        chk("len_out", 32'(n), EARLY ? 32'd3 : 32'd5);
        run_instr(2, 1'b1, 1'b0, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
